upstream_order_gate: RTL
========================

Name: upstream_order_gate

Overview:
Per-client pre-trade exposure gate on the upstream side of the order path. It is the issuing end of the per-client amount interface that the downstream cancel accumulator consumes.
- Accepts new orders (client_id, amount) and performs read-check-write on an internal per-client exposure RAM.
- Accepts or rejects each order against a fixed limit.
- Emits an ack pulse plus the accepted client_id/amount toward the downstream block.
- Takes cancel credits back in and lowers exposure for the cancelled client.

Parameters:
CLIENT_W, 5, client id width; RAM depth is 2**CLIENT_W.
AMOUNT_W, 32, amount and exposure width.
LIMIT, 32'd1000000, maximum allowed exposure per client; the comparison is inclusive.

Ports:
clk  in  1  single clock for all logic and the RAM.
rst  in  1  asynchronous reset, active-high.
order_valid  in  1  new order request.
order_ready  out  1  order taken on clk edge when order_valid && order_ready.
order_client_id  in  CLIENT_W  client of the order.
order_amount  in  AMOUNT_W  order amount.
cancel_valid  in  1  cancel credit request.
cancel_ready  out  1  cancel taken when cancel_valid && cancel_ready.
cancel_client_id  in  CLIENT_W  client of the cancel.
cancel_amount  in  AMOUNT_W  amount to release.
resp_valid  out  1  one-cycle pulse: order decision available.
resp_accept  out  1  1 = accepted, 0 = rejected; qualified by resp_valid.
resp_client_id  out  CLIENT_W  client of the decided order.
resp_exposure  out  AMOUNT_W  client exposure after the decision (unchanged if rejected).
ack  out  1  one-cycle pulse, equal to resp_valid && resp_accept; drives the downstream ack.
ack_client_id  out  CLIENT_W  client for the downstream; held until the next ack.
ack_amount  out  AMOUNT_W  accepted amount for the downstream; held until the next ack.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 and state = CLEAR.
  - RAM contents are not reset directly. CLEAR writes 0 to addresses 0..2**CLIENT_W-1, one per cycle, for 32 cycles at default.
  - order_ready and cancel_ready stay 0 until CLEAR completes, then state = IDLE.
- States:
  - CLEAR: sweep the RAM as above.
  - IDLE: order_ready = 1 and cancel_ready = 1 only here.
    - cancel_valid has priority. When cancel_valid = 1, order_ready = 0 in the same cycle.
    - On a handshake, latch kind (order/cancel), client_id and amount; drive the RAM read address; go to READ.
  - READ: the synchronous RAM data is valid at the end of this cycle; go to CHECK.
  - CHECK:
    - Order: compute sum = exposure + amount in AMOUNT_W+1 bits. Accept iff sum[AMOUNT_W] == 0 and sum <= LIMIT.
    - Cancel: new = exposure - amount, saturating at 0 when amount > exposure.
    - Go to WRITE.
  - WRITE:
    - Write new exposure if the request was an order and accepted, or was a cancel. Rejected orders do not write.
    - For orders, pulse resp_valid and set resp_* for this cycle. If accepted, also pulse ack and update ack_client_id/ack_amount.
    - Cancels produce no resp_valid and no ack.
    - Return to IDLE.
- Latency: handshake at edge N gives resp_valid high in cycle N+3. Throughput is one request per 4 cycles.
- Hazards: requests are fully serialised, so there is no read-after-write hazard and no forwarding is needed. The RAM read in READ always sees the previous WRITE.
- resp_* other than resp_valid hold their last value between pulses.
- amount = 0:
  - An order with amount 0 is always accepted, writes the unchanged value, and still pulses ack with amount 0.
  - A cancel with amount 0 is a no-op write.
- Reset mid-operation: the in-flight request is dropped, with no RAM write and no resp/ack. The block restarts CLEAR.
- Inputs are sampled only at the handshake. Changing them while ready = 0 has no effect.

Decomposition:
- Package upstream_pkg:
  - state enum {CLEAR, IDLE, READ, CHECK, WRITE};
  - CLIENT_W/AMOUNT_W defaults;
  - LIMIT default;
  - request-kind enum {REQ_ORDER, REQ_CANCEL}.
- One sub-module, exposure_ram: 1 read / 1 write port, synchronous read and write, depth 2**CLIENT_W, width AMOUNT_W, same clk, no reset.
- The FSM and arithmetic live in the top.

Test Plan:
- Reset, then hold order_valid = 1: order_ready stays 0 for exactly 32 cycles after rst falls. A first order (client 3, amount 100) returns resp_accept = 1, resp_exposure = 100, and ack with ack_client_id = 3, ack_amount = 100 at handshake+3.
- Client 3 at 100, order amount 999901: rejected, resp_exposure = 100, no ack. A following order of 999900 is accepted with resp_exposure = 1000000.
- Cancel client 3, amount 40 (exposure 100), then order of 0: resp_exposure = 60. Then cancel 500, then order of 0: resp_exposure = 0 (saturation).
- order_valid and cancel_valid both high in IDLE for client 7: the cancel is taken first with order_ready = 0 that cycle. The order is taken 4 cycles later and sees the post-cancel exposure.
- Build with LIMIT = 32'hFFFFFFFF, client 1 at 32'hFFFFFFF0, order 32'h20: carry detected, rejected, exposure unchanged.
- Assert rst during WRITE of an accepted order: no ack or resp_valid pulse; CLEAR reruns; the next order for that client sees exposure 0.

Source files
------------

// File: rtl/upstream_pkg.sv
// Shared types and default sizing for the upstream per-client exposure gate.
package upstream_pkg;

   localparam int DEF_CLIENT_W = 5;
   localparam int DEF_AMOUNT_W = 32;
   localparam logic [31:0] DEF_LIMIT = 32'd1000000;

   typedef enum logic [2:0] {CLEAR, IDLE, READ, CHECK, WRITE} state_t;

   typedef enum logic {REQ_ORDER, REQ_CANCEL} req_kind_t;

endpackage

// File: rtl/exposure_ram.sv
// Per-client exposure storage: one synchronous read port, one synchronous write port.
module exposure_ram #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/upstream_order_gate.sv
// Pre-trade exposure gate: serialised read-check-write of per-client exposure for orders
// and cancel credits, with response and downstream ack pulses.
module upstream_order_gate
   import upstream_pkg::*;
#(
   parameter int CLIENT_W = DEF_CLIENT_W,
   parameter int AMOUNT_W = DEF_AMOUNT_W,
   parameter logic [AMOUNT_W-1:0] LIMIT = AMOUNT_W'(DEF_LIMIT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                order_valid,
   output logic                order_ready,
   input  logic [CLIENT_W-1:0] order_client_id,
   input  logic [AMOUNT_W-1:0] order_amount,
   input  logic                cancel_valid,
   output logic                cancel_ready,
   input  logic [CLIENT_W-1:0] cancel_client_id,
   input  logic [AMOUNT_W-1:0] cancel_amount,
   output logic                resp_valid,
   output logic                resp_accept,
   output logic [CLIENT_W-1:0] resp_client_id,
   output logic [AMOUNT_W-1:0] resp_exposure,
   output logic                ack,
   output logic [CLIENT_W-1:0] ack_client_id,
   output logic [AMOUNT_W-1:0] ack_amount
);

   state_t              state;
   req_kind_t           kind;
   logic [CLIENT_W-1:0] req_client;
   logic [CLIENT_W-1:0] clear_cnt;
   logic [AMOUNT_W-1:0] req_amount;
   logic [AMOUNT_W-1:0] new_exp;
   logic                do_write;

   logic [AMOUNT_W-1:0] rdata;
   logic [AMOUNT_W:0]   sum;
   logic                order_ok;
   logic [AMOUNT_W-1:0] cancel_new;
   logic                ram_we;
   logic [CLIENT_W-1:0] ram_waddr;
   logic [AMOUNT_W-1:0] ram_wdata;

   assign cancel_ready = (state == IDLE);
   assign order_ready  = (state == IDLE) && !cancel_valid;

   always_comb begin
      sum        = {1'b0, rdata} + {1'b0, req_amount};
      // The carry bit catches wrap-around before the limit compare.
      order_ok   = !sum[AMOUNT_W] && (sum[AMOUNT_W-1:0] <= LIMIT);
      cancel_new = (req_amount > rdata) ? '0 : rdata - req_amount;
      ram_we     = (state == CLEAR) || ((state == WRITE) && do_write);
      ram_waddr  = (state == CLEAR) ? clear_cnt : req_client;
      ram_wdata  = (state == CLEAR) ? '0 : new_exp;
   end

   exposure_ram #(
      .ADDR_W(CLIENT_W),
      .DATA_W(AMOUNT_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .raddr(req_client),
      .rdata(rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= CLEAR;
         clear_cnt      <= '0;
         kind           <= REQ_ORDER;
         req_client     <= '0;
         req_amount     <= '0;
         new_exp        <= '0;
         do_write       <= 1'b0;
         resp_valid     <= 1'b0;
         resp_accept    <= 1'b0;
         resp_client_id <= '0;
         resp_exposure  <= '0;
         ack            <= 1'b0;
         ack_client_id  <= '0;
         ack_amount     <= '0;
      end else begin
         resp_valid <= 1'b0;
         ack        <= 1'b0;
         case (state)
            CLEAR: begin
               clear_cnt <= clear_cnt + 1'b1;
               if (clear_cnt == '1) state <= IDLE;
            end
            IDLE: begin
               if (cancel_valid) begin
                  kind       <= REQ_CANCEL;
                  req_client <= cancel_client_id;
                  req_amount <= cancel_amount;
                  state      <= READ;
               end else if (order_valid) begin
                  kind       <= REQ_ORDER;
                  req_client <= order_client_id;
                  req_amount <= order_amount;
                  state      <= READ;
               end
            end
            READ: state <= CHECK;
            CHECK: begin
               if (kind == REQ_ORDER) begin
                  new_exp  <= order_ok ? sum[AMOUNT_W-1:0] : rdata;
                  do_write <= order_ok;
               end else begin
                  new_exp  <= cancel_new;
                  do_write <= 1'b1;
               end
               state <= WRITE;
            end
            WRITE: begin
               if (kind == REQ_ORDER) begin
                  resp_valid     <= 1'b1;
                  resp_accept    <= do_write;
                  resp_client_id <= req_client;
                  resp_exposure  <= new_exp;
                  if (do_write) begin
                     ack           <= 1'b1;
                     ack_client_id <= req_client;
                     ack_amount    <= req_amount;
                  end
               end
               state <= IDLE;
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
